// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - ALU command issuer with carry flag, forwarding and in-order response FIFO
module alu_issuer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_use_carry,
    output logic       alu_valid_in,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [3:0] alu_ctl,
    input  logic       alu_valid_out,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic       carry_flag,
    output logic       proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic       err;
        logic       zero;
        logic       carry;
        logic [3:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pend_q, pend_d;
    logic          err_p_q, err_p_d;
    logic          carry_flag_q, carry_flag_d;
    logic          proto_err_q, proto_err_d;

    logic [CW:0]   occupancy;
    logic          accept;
    logic          op_ok;
    logic          push;
    logic          pop;
    entry_t        push_entry;
    entry_t        head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        // Credits cover both buffered entries and the command still inside the ALU.
        occupancy  = {1'b0, count_q} + (CW + 1)'(pend_q);
        cmd_ready  = reset & (occupancy < DEPTH_W);
        op_ok      = cmd_op < 4'd14;
        accept     = cmd_valid & cmd_ready;

        alu_valid_in = accept & op_ok;
        alu_a        = cmd_a;
        alu_b        = cmd_b;
        alu_ctl      = cmd_op;
        alu_cin      = cmd_use_carry &
                       ((pend_q & ~err_p_q & alu_valid_out) ? alu_carry : carry_flag_q);

        push       = pend_q & (err_p_q | alu_valid_out);
        pop        = (count_q != '0) & rsp_ready;
        push_entry = err_p_q ? entry_t'{err: 1'b1, zero: 1'b0, carry: 1'b0, data: 4'd0}
                             : entry_t'{err: 1'b0, zero: alu_zero, carry: alu_carry, data: alu_result};

        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        carry_flag_d = carry_flag_q;
        proto_err_d  = proto_err_q;
        pend_d       = accept;
        err_p_d      = accept & ~op_ok;

        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pend_q & ~err_p_q) begin
            if (alu_valid_out) begin
                carry_flag_d = alu_carry;
            end else begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pend_q       <= 1'b0;
            err_p_q      <= 1'b0;
            carry_flag_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            err_p_q      <= err_p_d;
            carry_flag_q <= carry_flag_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Entry storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rsp_valid  = count_q != '0;
        head       = rsp_valid ? mem_q[rd_ptr_q] : '0;
        rsp_data   = head.data;
        rsp_carry  = head.carry;
        rsp_zero   = head.zero;
        rsp_err    = head.err;
        carry_flag = carry_flag_q;
        proto_err  = proto_err_q;
    end
endmodule
